// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg: shared quadrant indices, mode encoding and sub-product mask
// for the split-operand approximate multiplier. Rev 1.0
`default_nettype none

package approx_mul_pkg;

  localparam int NUM_QUADS = 4;
  localparam int QUAD_LL   = 0;
  localparam int QUAD_LH   = 1;
  localparam int QUAD_HL   = 2;
  localparam int QUAD_HH   = 3;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  typedef logic [NUM_QUADS-1:0] quad_mode_t;

  // Keep-mask for a sub-product: ones everywhere except the low `drop` bits.
  function automatic logic [31:0] sub_mask(input int unsigned drop);
    return 32'hFFFF_FFFF << drop;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hslp_quad_mul.sv
// hslp_quad_mul: one H x H quadrant multiplier; approximate mode clears the
// low APX_DROP bits of the sub-product. Rev 1.0
`default_nettype none

module hslp_quad_mul
  import approx_mul_pkg::*;
#(
  parameter int H        = 4,
  parameter int APX_DROP = 2
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  input  logic           mode,
  output logic [2*H-1:0] prod
);

  localparam logic [31:0]    MASK_FULL = sub_mask(APX_DROP);
  localparam logic [2*H-1:0] MASK      = MASK_FULL[2*H-1:0];

  logic [2*H-1:0] exact;

  assign exact = {{H{1'b0}}, a} * {{H{1'b0}}, b};
  assign prod  = (mode == MODE_APPROX) ? (exact & MASK) : exact;

endmodule

`default_nettype wire

// File: rtl/hslp_pipe_mul.sv
// hslp_pipe_mul: three-stage valid/ready pipelined split-operand multiplier
// with per-quadrant approximate mode and a transfer counter. Rev 1.0
`default_nettype none

module hslp_pipe_mul
  import approx_mul_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int APX_DROP = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [3:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [3:0]         out_mode,
  output logic [15:0]        op_cnt
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  logic                            s1_valid, s2_valid, s3_valid;
  logic [WIDTH-1:0]                s1_a, s1_b;
  quad_mode_t                      s1_mode, s2_mode, s3_mode;
  logic [NUM_QUADS-1:0][2*H-1:0]   quad_prod, s2_sub;
  logic [PW-1:0]                   sum, s3_prod;
  logic                            s1_free, s2_free, s3_free;

  // A stage may load when it is empty or its contents move on this cycle,
  // so a downstream stall ripples back to in_ready combinationally.
  assign s3_free  = !s3_valid || out_ready;
  assign s2_free  = !s2_valid || s3_free;
  assign s1_free  = !s1_valid || s2_free;
  assign in_ready = rst_n && s1_free;

  for (genvar q = 0; q < NUM_QUADS; q++) begin : g_quad
    localparam bit A_HI = (q == QUAD_HL) || (q == QUAD_HH);
    localparam bit B_HI = (q == QUAD_LH) || (q == QUAD_HH);
    hslp_quad_mul #(
      .H        (H),
      .APX_DROP (APX_DROP)
    ) u_quad (
      .a    (A_HI ? s1_a[WIDTH-1:H] : s1_a[H-1:0]),
      .b    (B_HI ? s1_b[WIDTH-1:H] : s1_b[H-1:0]),
      .mode (s1_mode[q]),
      .prod (quad_prod[q])
    );
  end

  always_comb begin
    sum = PW'(s2_sub[QUAD_LL])
        + (PW'(s2_sub[QUAD_LH]) << H)
        + (PW'(s2_sub[QUAD_HL]) << H)
        + (PW'(s2_sub[QUAD_HH]) << (2 * H));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '0;
    end else if (s1_free) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_mode <= in_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sub   <= '0;
      s2_mode  <= '0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sub  <= quad_prod;
        s2_mode <= s1_mode;
      end
    end
  end

  // Output registers only change when the result slot is free, which keeps
  // out_prod/out_mode frozen during an output stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_prod  <= '0;
      s3_mode  <= '0;
    end else if (s3_free) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_prod <= sum;
        s3_mode <= s2_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt <= '0;
    end else if (s3_valid && out_ready) begin
      op_cnt <= op_cnt + 16'd1;
    end
  end

  assign out_valid = s3_valid;
  assign out_prod  = s3_prod;
  assign out_mode  = s3_mode;

endmodule

`default_nettype wire
